// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants for the VGA sync generator and the pattern generator.
// The defaults describe 640x480 @ 60 Hz with an 800x525 total raster.
package vga_timing_pkg;

    localparam int DEF_ACTIVE_COLS = 640;
    localparam int DEF_H_FP        = 16;
    localparam int DEF_H_SYNC      = 96;
    localparam int DEF_H_BP        = 48;
    localparam int DEF_ACTIVE_ROWS = 480;
    localparam int DEF_V_FP        = 10;
    localparam int DEF_V_SYNC      = 2;
    localparam int DEF_V_BP        = 33;

    localparam int DEF_POS_W = 10;

    // Asserted level of HSYNC/VSYNC for the standard 640x480 mode.
    localparam logic SYNC_ACTIVE_LOW = 1'b0;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter plus its active/sync window decode.
// Used once for columns (stepped per pixel) and once for rows (stepped per line wrap).
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_ACTIVE_COLS,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter int POS_W  = DEF_POS_W
) (
    input  logic             i_CLK,
    input  logic             i_RESET,
    input  logic             i_STEP,
    output logic [POS_W-1:0] o_COUNT,
    output logic             o_WRAP,
    output logic             o_ACTIVE,
    output logic             o_SYNC
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

    generate
        if (FP <= 0 || SYNC <= 0 || BP <= 0) begin : g_bad_porch
            $fatal(1, "vga_axis_counter: porch and sync widths must be non-zero");
        end
        if (longint'(TOTAL) > (longint'(1) << POS_W)) begin : g_bad_width
            $fatal(1, "vga_axis_counter: axis total does not fit in POS_W bits");
        end
    endgenerate

    localparam logic [POS_W-1:0] LAST       = POS_W'(TOTAL - 1);
    localparam logic [POS_W-1:0] ACT_LIM    = POS_W'(ACTIVE);
    localparam logic [POS_W-1:0] SYNC_FIRST = POS_W'(ACTIVE + FP);
    localparam logic [POS_W-1:0] SYNC_LAST  = POS_W'(ACTIVE + FP + SYNC - 1);

    logic [POS_W-1:0] count_p0;

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            count_p0 <= '0;
        end else if (i_STEP) begin
            count_p0 <= o_WRAP ? '0 : count_p0 + POS_W'(1);
        end
    end

    assign o_COUNT  = count_p0;
    assign o_WRAP   = (count_p0 == LAST);
    assign o_ACTIVE = (count_p0 < ACT_LIM);
    assign o_SYNC   = (count_p0 >= SYNC_FIRST) && (count_p0 <= SYNC_LAST);

endmodule

// File: rtl/vga_sync_timing.sv
// Raster timing generator: advances one pixel per enabled clock and presents
// registered sync, active, position and line/frame strobes for that pixel.
module vga_sync_timing
    import vga_timing_pkg::*;
#(
    parameter int   ACTIVE_COLS = DEF_ACTIVE_COLS,
    parameter int   H_FP        = DEF_H_FP,
    parameter int   H_SYNC      = DEF_H_SYNC,
    parameter int   H_BP        = DEF_H_BP,
    parameter int   ACTIVE_ROWS = DEF_ACTIVE_ROWS,
    parameter int   V_FP        = DEF_V_FP,
    parameter int   V_SYNC      = DEF_V_SYNC,
    parameter int   V_BP        = DEF_V_BP,
    parameter logic SYNC_POL    = SYNC_ACTIVE_LOW,
    parameter int   POS_W       = DEF_POS_W
) (
    input  logic             i_CLK,
    input  logic             i_RESET,
    input  logic             i_EN,
    output logic             o_HSYNC,
    output logic             o_VSYNC,
    output logic             o_ACTIVE,
    output logic [POS_W-1:0] o_COL,
    output logic [POS_W-1:0] o_ROW,
    output logic             o_LINE_START,
    output logic             o_FRAME_START
);

    function automatic logic sync_level(input logic asserted);
        return asserted ? SYNC_POL : ~SYNC_POL;
    endfunction

    logic [POS_W-1:0] h_count, v_count;
    logic             h_wrap, h_active, h_sync;
    logic             v_wrap_unused, v_active, v_sync;

    vga_axis_counter #(
        .ACTIVE (ACTIVE_COLS),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POS_W  (POS_W)
    ) u_h_axis (
        .i_CLK    (i_CLK),
        .i_RESET  (i_RESET),
        .i_STEP   (i_EN),
        .o_COUNT  (h_count),
        .o_WRAP   (h_wrap),
        .o_ACTIVE (h_active),
        .o_SYNC   (h_sync)
    );

    vga_axis_counter #(
        .ACTIVE (ACTIVE_ROWS),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POS_W  (POS_W)
    ) u_v_axis (
        .i_CLK    (i_CLK),
        .i_RESET  (i_RESET),
        .i_STEP   (i_EN & h_wrap),
        .o_COUNT  (v_count),
        .o_WRAP   (v_wrap_unused),
        .o_ACTIVE (v_active),
        .o_SYNC   (v_sync)
    );

    logic             hsync_p1, vsync_p1, active_p1;
    logic [POS_W-1:0] col_p1, row_p1;
    logic             line_start_p1, frame_start_p1;

    // Stage p0 -> p1: decode of the counter state is registered; strobes only live for one enabled clock.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            hsync_p1       <= ~SYNC_POL;
            vsync_p1       <= ~SYNC_POL;
            active_p1      <= 1'b0;
            col_p1         <= '0;
            row_p1         <= '0;
            line_start_p1  <= 1'b0;
            frame_start_p1 <= 1'b0;
        end else if (i_EN) begin
            hsync_p1       <= sync_level(h_sync);
            vsync_p1       <= sync_level(v_sync);
            active_p1      <= h_active & v_active;
            col_p1         <= h_count;
            row_p1         <= v_count;
            line_start_p1  <= (h_count == '0);
            frame_start_p1 <= (h_count == '0) && (v_count == '0);
        end else begin
            line_start_p1  <= 1'b0;
            frame_start_p1 <= 1'b0;
        end
    end

    assign o_HSYNC       = hsync_p1;
    assign o_VSYNC       = vsync_p1;
    assign o_ACTIVE      = active_p1;
    assign o_COL         = col_p1;
    assign o_ROW         = row_p1;
    assign o_LINE_START  = line_start_p1;
    assign o_FRAME_START = frame_start_p1;

endmodule

// File: doc/vga_sync_timing.md
Name: vga_sync_timing

Overview:
Raster timing generator that sits directly upstream of the test pattern generator and drives its sync and position inputs. It produces HSYNC/VSYNC, an active-video flag, the current column/row and line/frame start strobes, all aligned to the same pixel. The block advances one pixel per cycle in which the pixel enable is high, so one system clock can drive a slower pixel rate. Defaults are 640x480 @ 60 Hz (800x525 total).

Parameters:
ACTIVE_COLS, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
ACTIVE_ROWS, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, asserted level of HSYNC/VSYNC (0 = active-low)
POS_W, 10, width of column/row counters; must satisfy 2^POS_W >= H total and >= V total

Ports:
i_CLK  input  1  system clock
i_RESET  input  1  synchronous reset, active-high
i_EN  input  1  pixel enable; one pixel advance per high cycle
o_HSYNC  output  1  horizontal sync, level per SYNC_POL
o_VSYNC  output  1  vertical sync, level per SYNC_POL
o_ACTIVE  output  1  high when (o_COL,o_ROW) is inside the visible area
o_COL  output  POS_W  column of the presented pixel, 0..H_TOTAL-1
o_ROW  output  POS_W  row of the presented pixel, 0..V_TOTAL-1
o_LINE_START  output  1  one-clock pulse when the presented pixel has col 0
o_FRAME_START  output  1  one-clock pulse when the presented pixel has col 0, row 0

Behaviour:
- H_TOTAL = ACTIVE_COLS+H_FP+H_SYNC+H_BP; V_TOTAL = ACTIVE_ROWS+V_FP+V_SYNC+V_BP.
- Internal position counters r_col, r_row.
- Reset (i_RESET=1 at a clock edge) overrides i_EN. It sets r_col=0 and r_row=0. Outputs go to: o_HSYNC=o_VSYNC=~SYNC_POL, o_ACTIVE=0, o_COL=0, o_ROW=0, both strobes 0.
- Each edge with i_RESET=0 and i_EN=1 does two things:
  - Output registers load the decode of the current (r_col,r_row).
  - The counters advance: r_col+1, or wrap to 0 at H_TOTAL-1. r_row increments only on the r_col wrap and wraps to 0 at V_TOTAL-1.
- The first enabled cycle after reset therefore presents (0,0) with o_FRAME_START=1.
- Decode rules:
  - ACTIVE = col<ACTIVE_COLS AND row<ACTIVE_ROWS.
  - HSYNC is asserted for col in [ACTIVE_COLS+H_FP, ACTIVE_COLS+H_FP+H_SYNC-1].
  - VSYNC is asserted for row in [ACTIVE_ROWS+V_FP, ACTIVE_ROWS+V_FP+V_SYNC-1], for whole lines, so its edges coincide with col 0.
- Edges with i_EN=0: counters and the level outputs (sync, active, col, row) hold; both strobes are forced to 0. Strobes are always single-clock pulses, whatever the i_EN duty.
- Latency is 1 clock from counter state to outputs. All outputs are mutually aligned; no output is combinational from the inputs.
- Reset mid-frame takes effect on that edge. There is no partial-line recovery; the next enabled cycle presents (0,0).
- Boundary conditions:
  - (H_TOTAL-1, V_TOTAL-1) is followed by (0,0) with both strobes high.
  - Row wrap and column wrap occurring on the same edge are handled without a skipped or duplicated line.
- Elaboration check: a zero value for any porch or sync parameter, or a total that exceeds 2^POS_W, is a fatal elaboration error.

Decomposition:
- Shared package vga_timing_pkg holds:
  - Default timing constants for 640x480@60.
  - The POS_W default.
  - A sync-polarity constant.
- The test pattern generator imports the same package.
- One natural sub-module is vga_axis_counter, instantiated once per axis. It takes ACTIVE/FP/SYNC/BP parameters and inputs i_CLK, i_RESET, i_STEP. It outputs the count, wrap, active and sync signals.
  - The horizontal instance has i_STEP = i_EN.
  - The vertical instance has i_STEP = i_EN AND the horizontal wrap.
- The top level registers the decoded outputs and generates the strobes.

Test Plan:
- Reset check: hold i_RESET=1 for 5 clocks with i_EN=1 -> o_COL=0, o_ROW=0, o_ACTIVE=0, o_HSYNC=o_VSYNC=1, strobes 0. The first enabled edge after release presents col 0, row 0, o_ACTIVE=1, o_FRAME_START=1.
- Horizontal timing: i_EN=1 continuously, defaults -> o_HSYNC=0 exactly while o_COL is 656..751. o_ACTIVE=1 for o_COL 0..639 on rows 0..479. o_LINE_START every 800 clocks.
- Vertical timing: o_VSYNC=0 exactly for rows 490..491 (1600 clocks). o_FRAME_START period is 420000 clocks. The pixel after (799,524) is (0,0).
- Enable gating: i_EN high 1 clock in 4 -> same col/row sequence at 1/4 rate. Strobes are 1 clock wide. Sync/active hold between enables.
- Mid-frame reset: assert i_RESET for 1 clock at (300,200) -> the next enabled output is (0,0) with o_FRAME_START=1, and sync inactive during the reset clock.
- Small geometry plus polarity: ACTIVE_COLS=4, H_FP=1, H_SYNC=2, H_BP=1, ACTIVE_ROWS=3, V_FP=1, V_SYNC=1, V_BP=1, SYNC_POL=1. Exhaustive compare against a reference model over 3 frames; HSYNC is high at cols 5..6 and VSYNC high at row 4.
